// File: rtl/mul_result_collector.sv
// Collects completed Booth-multiplier products, sums them in blocks of BLOCK_LEN
// with saturation, and queues block sums in a 2-entry valid/ready output FIFO.
module mul_result_collector #(
    parameter int ACC_W     = 24,
    parameter int BLOCK_LEN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [15:0]      p,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    busy,
    output logic                    sat,
    output logic                    overflow
);

    typedef enum logic {
        ACCUM     = 1'b0,
        FULL_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]              LAST_CNT = 4'(BLOCK_LEN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // The extra top bit disagrees with the ACC_W sign bit only on overflow.
    function automatic logic is_sat(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
        if (is_sat(s)) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    logic                    r_rdy_q;
    logic signed [ACC_W-1:0] r_acc;
    logic [3:0]              r_cnt;
    logic                    r_sat;
    logic                    r_ovf;
    logic signed [ACC_W-1:0] r_head;
    logic signed [ACC_W-1:0] r_tail;
    logic [1:0]              r_occ;
    state_t                  r_state;

    state_t                  w_state_nxt;
    logic                    w_full;
    logic                    w_capture;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_clamped;
    logic                    w_push;
    logic                    w_push_acc;
    logic                    w_pop;
    logic                    w_drop;
    logic [1:0]              w_occ_nxt;

    assign w_capture  = rdy & ~r_rdy_q;
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-15){p[15]}}, p};
    assign w_clamped  = sat_clamp(w_sum);
    assign w_push     = w_capture & (r_cnt == LAST_CNT);
    assign w_pop      = out_valid & out_ready;
    // A pop frees the slot first, so a full FIFO still accepts a push alongside it.
    assign w_push_acc = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_occ_nxt  = r_occ + {1'b0, w_push_acc} - {1'b0, w_pop};

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_head;
    assign busy      = (r_cnt != 4'd0);
    assign sat       = r_sat;
    assign overflow  = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_q <= 1'b0;
        end else begin
            r_rdy_q <= rdy;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= 4'd0;
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= 4'd0;
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_capture) begin
                if (w_push) begin
                    r_acc <= '0;
                    r_cnt <= 4'd0;
                end else begin
                    r_acc <= w_clamped;
                    r_cnt <= r_cnt + 4'd1;
                end
                if (is_sat(w_sum)) begin
                    r_sat <= 1'b1;
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else if (clear) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push_acc, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= w_clamped;
                    end else begin
                        r_tail <= w_clamped;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= w_clamped;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_clamped;
                    end
                end
                default: begin
                end
            endcase
            r_occ <= w_occ_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ACCUM;
        end else begin
            case (r_state)
                ACCUM:     if (w_occ_nxt == 2'd2) w_state_nxt = FULL_WAIT;
                FULL_WAIT: if (w_occ_nxt != 2'd2) w_state_nxt = ACCUM;
                default:   w_state_nxt = ACCUM;
            endcase
        end
    end

    always_comb begin
        w_full = (r_state == FULL_WAIT);
    end

endmodule
